// File: rtl/elastic_pipe_chain.sv
// Purpose: elastic register chain of STAGES x WIDTH with valid/ready, stall, masked flush, bubble collapse.
// Latency: STAGES cycles from accept to o_valid when unblocked; +1 per item while the skid drains.
// Backpressure: ready ripples back from i_ready through empty stages; ELASTIC_PIPE_SKID_EN adds a skid so o_ready is a flop.
module elastic_pipe_chain #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4,
   parameter int CNT_W  = $clog2(STAGES + 2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic [STAGES-1:0] i_flush_mask,
   input  logic              i_valid,
   input  logic [WIDTH-1:0]  i_data,
   output logic              o_ready,
   output logic              o_valid,
   output logic [WIDTH-1:0]  o_data,
   input  logic              i_ready,
   output logic [CNT_W-1:0]  o_count,
   output logic [STAGES-1:0] o_stage_valid
);

   logic [STAGES-1:0] valid;
   logic [WIDTH-1:0]  data [STAGES];
   logic [STAGES:0]   rdy;        // rdy[k]: stage k may be written this cycle
   logic              rdy_acc;
   logic [STAGES-1:0] take;       // stage k receives an item this cycle
   logic [STAGES-1:0] valid_nxt;
   logic [STAGES-1:0] kill;
   logic              src_vld;    // item offered to stage 0
   logic [WIDTH-1:0]  src_dat;
   logic              skid_nxt;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nxt;

   assign kill = i_flush ? i_flush_mask : '0;

`ifdef ELASTIC_PIPE_SKID_EN
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             skid_load;

   // A held skid entry always goes first so ordering is preserved; upstream is only
   // accepted while the skid is empty, and lands in the skid if stage 0 is blocked.
   assign src_vld   = skid_valid | i_valid;
   assign src_dat   = skid_valid ? skid_data : i_data;
   assign skid_load = ~skid_valid & i_valid & ~rdy[0];
   assign skid_nxt  = ((skid_valid & ~rdy[0]) | skid_load) & ~kill[0];
   assign o_ready   = ~skid_valid;

   // Skid register: valid is cleared by reset or a stage-0 flush
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else begin
         skid_valid <= skid_nxt;
         if (skid_load) begin
            skid_data <= i_data;
         end
      end
   end
`else
   assign src_vld  = i_valid;
   assign src_dat  = i_data;
   assign skid_nxt = 1'b0;
   assign o_ready  = rdy[0];
`endif

   // Ready chain: an empty stage is always ready, a full one only if it can pass on
   always_comb begin
      rdy     = '0;
      rdy_acc = i_ready & ~i_stall;
      rdy[STAGES] = rdy_acc;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy_acc = ~i_stall & (~valid[k] | rdy_acc);
         rdy[k]  = rdy_acc;
      end
   end

   // Next valid state: receive, hold or drain, then squash masked stages
   always_comb begin
      take      = '0;
      valid_nxt = '0;
      take[0]   = src_vld & rdy[0];
      for (int k = 1; k < STAGES; k++) begin
         take[k] = valid[k-1] & rdy[k];
      end
      for (int k = 0; k < STAGES; k++) begin
         valid_nxt[k] = (take[k] | (valid[k] & ~rdy[k+1])) & ~kill[k];
      end
   end

   // Occupancy of the next state, including the skid entry
   always_comb begin
      count_nxt = CNT_W'(skid_nxt);
      for (int k = 0; k < STAGES; k++) begin
         count_nxt = count_nxt + CNT_W'(valid_nxt[k]);
      end
   end

   // Stage registers: data moves only on an accepted transfer, never on flush
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
         count <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data[k] <= '0;
         end
      end else begin
         valid <= valid_nxt;
         count <= count_nxt;
         if (take[0]) begin
            data[0] <= src_dat;
         end
         for (int k = 1; k < STAGES; k++) begin
            if (take[k]) begin
               data[k] <= data[k-1];
            end
         end
      end
   end

   assign o_valid       = valid[STAGES-1];
   assign o_data        = data[STAGES-1];
   assign o_count       = count;
   assign o_stage_valid = valid;

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Bench for elastic_pipe_chain (STAGES=4, WIDTH=32); honours ELASTIC_PIPE_SKID_EN if defined.
// Directed scenarios with fixed expectations, then randomized traffic against a slot model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_elastic_pipe_chain;
   localparam int WIDTH  = 32;
   localparam int STAGES = 4;
   localparam int CNT_W  = $clog2(STAGES + 2);
`ifdef ELASTIC_PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              i_stall;
   logic              i_flush;
   logic [STAGES-1:0] i_flush_mask;
   logic              i_valid;
   logic [WIDTH-1:0]  i_data;
   logic              o_ready;
   logic              o_valid;
   logic [WIDTH-1:0]  o_data;
   logic              i_ready;
   logic [CNT_W-1:0]  o_count;
   logic [STAGES-1:0] o_stage_valid;

   int checks   = 0;
   int failures = 0;
   logic [WIDTH-1:0] outq [$];

   elastic_pipe_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush),
      .i_flush_mask(i_flush_mask), .i_valid(i_valid), .i_data(i_data),
      .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
      .o_count(o_count), .o_stage_valid(o_stage_valid)
   );

   always #5 clk = ~clk;

   // One clock: drive inputs, sample, log any output handshake, advance to next falling edge
   task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r,
                        input logic st, input logic fl, input logic [STAGES-1:0] m,
                        output logic ov, output logic [CNT_W-1:0] cnt);
      i_valid = v; i_data = d; i_ready = r; i_stall = st; i_flush = fl; i_flush_mask = m;
      #1;
      ov  = o_valid;
      cnt = o_count;
      if (o_valid && i_ready && !i_stall) outq.push_back(o_data);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      i_valid = 0; i_data = '0; i_ready = 0; i_stall = 0; i_flush = 0; i_flush_mask = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      outq.delete();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 0;
      #1;
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
      checks++; if (o_data !== '0) begin failures++; $display("FAIL reset_o_data got=%h exp=0", o_data); end
      checks++; if (o_count !== '0) begin failures++; $display("FAIL reset_o_count got=%0d exp=0", o_count); end
      checks++; if (o_stage_valid !== '0) begin failures++; $display("FAIL reset_stage_valid got=%b exp=0", o_stage_valid); end
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b exp=1", o_ready); end
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_stream();
      logic ov; logic [CNT_W-1:0] cnt;
      int first = -1; int nval = 0; int peak = 0;
      logic [WIDTH-1:0] exp_q [$] = '{32'h11, 32'h22, 32'h33};
      logic [WIDTH-1:0] got;
      do_reset();
      for (int n = 0; n < 12; n++) begin
         cycle(n < 3, WIDTH'(32'h11 * (n + 1)), 1'b1, 1'b0, 1'b0, '0, ov, cnt);
         if (ov) begin nval++; if (first < 0) first = n; end
         if (int'(cnt) > peak) peak = int'(cnt);
      end
      checks++; if (first != STAGES) begin failures++; $display("FAIL stream_latency got=%0d exp=%0d", first, STAGES); end
      checks++; if (nval != 3) begin failures++; $display("FAIL stream_valid_cycles got=%0d exp=3", nval); end
      checks++; if (peak != 3) begin failures++; $display("FAIL stream_peak_count got=%0d exp=3", peak); end
      checks++; if (outq.size() != 3) begin failures++; $display("FAIL stream_items got=%0d exp=3", outq.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < outq.size()) ? outq[i] : 'x;
         checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic ov; logic [CNT_W-1:0] cnt;
      logic [WIDTH-1:0] got;
      do_reset();
      for (int n = 0; n < 4; n++) cycle(1'b1, WIDTH'(n + 1), 1'b0, 1'b0, 1'b0, '0, ov, cnt);
      idle_inputs();
      #1;
      checks++; if (o_count !== CNT_W'(4)) begin failures++; $display("FAIL bp_full_count got=%0d exp=4", o_count); end
      checks++; if (o_ready !== SKID) begin failures++; $display("FAIL bp_full_ready got=%b exp=%b", o_ready, SKID); end
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, ov, cnt);
      idle_inputs();
      #1;
      checks++; if (outq.size() != 1) begin failures++; $display("FAIL bp_one_left got=%0d exp=1", outq.size()); end
      checks++; if (o_count !== CNT_W'(3)) begin failures++; $display("FAIL bp_after_count got=%0d exp=3", o_count); end
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL bp_after_ready got=%b exp=1", o_ready); end
      for (int n = 0; n < 6; n++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, ov, cnt);
      checks++; if (outq.size() != 4) begin failures++; $display("FAIL bp_items got=%0d exp=4", outq.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < outq.size()) ? outq[i] : 'x;
         checks++; if (got !== WIDTH'(i + 1)) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got, i + 1); end
      end
   endtask

   task automatic test_stall();
      logic ov; logic [CNT_W-1:0] cnt;
      logic [WIDTH-1:0] got;
      do_reset();
      cycle(1'b1, 32'h21, 1'b1, 1'b0, 1'b0, '0, ov, cnt);
      cycle(1'b1, 32'h22, 1'b1, 1'b0, 1'b0, '0, ov, cnt);
      i_valid = 0; i_ready = 1; i_stall = 1;
      #1;
      checks++; if (o_ready !== SKID) begin failures++; $display("FAIL stall_ready got=%b exp=%b", o_ready, SKID); end
      for (int n = 0; n < 3; n++) begin
         cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, ov, cnt);
         checks++; if (cnt !== CNT_W'(2)) begin failures++; $display("FAIL stall_count[%0d] got=%0d exp=2", n, cnt); end
      end
      #1;
      checks++; if (o_stage_valid !== 4'b0011) begin failures++; $display("FAIL stall_stage_valid got=%b exp=0011", o_stage_valid); end
      checks++; if (outq.size() != 0) begin failures++; $display("FAIL stall_moved got=%0d exp=0", outq.size()); end
      for (int n = 0; n < 6; n++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, ov, cnt);
      for (int i = 0; i < 2; i++) begin
         got = (i < outq.size()) ? outq[i] : 'x;
         checks++; if (got !== WIDTH'(32'h21 + i)) begin failures++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, got, 32'h21 + i); end
      end
   endtask

   task automatic test_flush();
      logic ov; logic [CNT_W-1:0] cnt;
      logic [WIDTH-1:0] got;
      logic [WIDTH-1:0] exp_q [$] = '{32'hD, 32'hC};
      do_reset();
      // push D first so stage k ends up holding 0xA+k
      for (int n = 0; n < 4; n++) cycle(1'b1, WIDTH'(32'hD - n), 1'b0, 1'b0, 1'b0, '0, ov, cnt);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'b0011, ov, cnt);
      idle_inputs();
      #1;
      checks++; if (o_count !== CNT_W'(2)) begin failures++; $display("FAIL flush_count got=%0d exp=2", o_count); end
      checks++; if (o_stage_valid !== 4'b1100) begin failures++; $display("FAIL flush_stage_valid got=%b exp=1100", o_stage_valid); end
      checks++; if (o_data !== 32'hD) begin failures++; $display("FAIL flush_head got=%h exp=d", o_data); end
      for (int n = 0; n < 6; n++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, ov, cnt);
      checks++; if (outq.size() != 2) begin failures++; $display("FAIL flush_items got=%0d exp=2", outq.size()); end
      for (int i = 0; i < 2; i++) begin
         got = (i < outq.size()) ? outq[i] : 'x;
         checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL flush_data[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid();
      logic ov; logic [CNT_W-1:0] cnt;
      int first = -1;
      do_reset();
      for (int n = 0; n < 3; n++) cycle(1'b1, WIDTH'(32'h31 + n), 1'b0, 1'b0, 1'b0, '0, ov, cnt);
      i_valid = 0; i_ready = 1;
      #2 rst = 0;
      #1;
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_o_valid got=%b exp=0", o_valid); end
      checks++; if (o_count !== '0) begin failures++; $display("FAIL rstmid_o_count got=%0d exp=0", o_count); end
      checks++; if (o_stage_valid !== '0) begin failures++; $display("FAIL rstmid_stage_valid got=%b exp=0", o_stage_valid); end
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      outq.delete();
      for (int n = 0; n < 8; n++) begin
         cycle(n == 0, 32'h55, 1'b1, 1'b0, 1'b0, '0, ov, cnt);
         if (ov && first < 0) first = n;
      end
      checks++; if (first != STAGES) begin failures++; $display("FAIL rstmid_latency got=%0d exp=%0d", first, STAGES); end
      checks++; if (outq.size() != 1 || outq[0] !== 32'h55) begin
         failures++; $display("FAIL rstmid_item got_n=%0d exp=1 item 55", outq.size());
      end
   endtask

`ifdef ELASTIC_PIPE_SKID_EN
   task automatic test_skid();
      logic ov; logic [CNT_W-1:0] cnt;
      logic [WIDTH-1:0] got;
      do_reset();
      for (int n = 0; n < 5; n++) cycle(1'b1, WIDTH'(32'h61 + n), 1'b0, 1'b0, 1'b0, '0, ov, cnt);
      idle_inputs();
      #1;
      checks++; if (o_count !== CNT_W'(5)) begin failures++; $display("FAIL skid_count got=%0d exp=5", o_count); end
      checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL skid_ready got=%b exp=0", o_ready); end
      for (int n = 0; n < 10; n++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, ov, cnt);
      checks++; if (outq.size() != 5) begin failures++; $display("FAIL skid_items got=%0d exp=5", outq.size()); end
      for (int i = 0; i < 5; i++) begin
         got = (i < outq.size()) ? outq[i] : 'x;
         checks++; if (got !== WIDTH'(32'h61 + i)) begin failures++; $display("FAIL skid_data[%0d] got=%h exp=%h", i, got, 32'h61 + i); end
      end
   endtask
`endif

   // Random traffic against a slot model: items advance from the output end one slot at a time
   task automatic test_random();
      logic [STAGES-1:0] mv, nv;
      logic [WIDTH-1:0]  md [STAGES];
      logic [WIDTH-1:0]  nd [STAGES];
      logic              sv, nsv;
      logic [WIDTH-1:0]  sd, nsd;
      logic              pos0_free, exp_rdy;
      int                exp_cnt;
      do_reset();
      mv = '0; sv = 0; sd = '0;
      for (int k = 0; k < STAGES; k++) md[k] = '0;
      for (int n = 0; n < 600; n++) begin
         i_valid      = ($urandom_range(9) < 7);
         i_data       = $urandom;
         i_ready      = ($urandom_range(9) < 6);
         i_stall      = ($urandom_range(7) == 0);
         i_flush      = ($urandom_range(9) == 0);
         i_flush_mask = STAGES'($urandom);
         exp_cnt = int'(sv);
         for (int k = 0; k < STAGES; k++) exp_cnt += int'(mv[k]);
         nv = mv; nd = md; nsv = sv; nsd = sd;
         if (!i_stall) begin
            if (nv[STAGES-1] && i_ready) nv[STAGES-1] = 0;
            for (int p = STAGES - 2; p >= 0; p--) begin
               if (nv[p] && !nv[p+1]) begin nv[p+1] = 1; nd[p+1] = nd[p]; nv[p] = 0; end
            end
         end
         pos0_free = !i_stall && !nv[0];
         if (SKID) begin
            exp_rdy = !sv;
            if (sv) begin
               if (pos0_free) begin nv[0] = 1; nd[0] = sd; nsv = 0; end
            end else if (i_valid) begin
               if (pos0_free) begin nv[0] = 1; nd[0] = i_data; end
               else begin nsv = 1; nsd = i_data; end
            end
         end else begin
            exp_rdy = pos0_free;
            if (i_valid && pos0_free) begin nv[0] = 1; nd[0] = i_data; end
         end
         if (i_flush) begin
            nv = nv & ~i_flush_mask;
            if (i_flush_mask[0]) nsv = 0;
         end
         #1;
         checks++; if (o_valid !== mv[STAGES-1]) begin failures++; $display("FAIL rnd_o_valid cyc=%0d got=%b exp=%b", n, o_valid, mv[STAGES-1]); end
         checks++; if (o_data !== md[STAGES-1]) begin failures++; $display("FAIL rnd_o_data cyc=%0d got=%h exp=%h", n, o_data, md[STAGES-1]); end
         checks++; if (o_count !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL rnd_o_count cyc=%0d got=%0d exp=%0d", n, o_count, exp_cnt); end
         checks++; if (o_ready !== exp_rdy) begin failures++; $display("FAIL rnd_o_ready cyc=%0d got=%b exp=%b", n, o_ready, exp_rdy); end
         checks++; if (o_stage_valid !== mv) begin failures++; $display("FAIL rnd_stage_valid cyc=%0d got=%b exp=%b", n, o_stage_valid, mv); end
         @(posedge clk);
         mv = nv; md = nd; sv = nsv; sd = nsd;
         @(negedge clk);
      end
   endtask

   initial begin
      clk = 0;
      rst = 0;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_stall();
      test_flush();
      test_reset_mid();
`ifdef ELASTIC_PIPE_SKID_EN
      test_skid();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
